// File: rtl/sized_fifo_enq_arb_pkg.sv
// Shared types for the SizedFIFO enqueue arbiter: clear-sequencer FSM states and error-message prefix.
package sized_fifo_enq_arb_pkg;

  // Clear sequencer: RUN -> QUIESCE -> CLEAR -> ACK -> RUN
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    QUIESCE = 2'd1,
    CLEAR   = 2'd2,
    ACK     = 2'd3
  } arb_state_e;

  localparam string ERR_PREFIX = "Error: sized_fifo_enq_arb:";

endpackage

// File: rtl/sized_fifo_enq_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, modulo nreq.
// Ports:
//   req   in  nreq       request vector
//   ptr   in  ptr_width  highest-priority requester index (always < nreq)
//   grant out nreq       one-hot winner, zero when no request
//   idx   out ptr_width  encoded winner index (don't-care when no request)
module sized_fifo_enq_arb_rr_pick #(
  parameter int unsigned nreq      = 4,
  parameter int unsigned ptr_width = 2
) (
  input  logic [nreq-1:0]      req,
  input  logic [ptr_width-1:0] ptr,
  output logic [nreq-1:0]      grant,
  output logic [ptr_width-1:0] idx
);

  localparam int unsigned SW = ptr_width + 1;
  localparam int unsigned DW = $clog2(2 * nreq);

  logic [2*nreq-1:0]   req_dbl;
  logic [DW-1:0]       rot_base;
  logic [nreq-1:0]     rot;
  logic [ptr_width-1:0] off;
  logic [SW-1:0]       sum;
  logic                any_req;

  // Doubling the vector makes the rotation a plain part-select for any nreq.
  assign req_dbl  = {req, req};
  assign rot_base = DW'(ptr);
  assign rot      = req_dbl[rot_base +: nreq];

  // Priority-encode the rotated vector, then add ptr back with an explicit wrap.
  always_comb begin
    any_req = 1'b0;
    off     = '0;
    for (int k = nreq - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any_req = 1'b1;
        off     = ptr_width'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= SW'(nreq)) sum = sum - SW'(nreq);
    idx   = sum[ptr_width-1:0];
    grant = any_req ? (nreq'(1) << idx) : '0;
  end

endmodule

// File: rtl/sized_fifo_enq_arb.sv
// Round-robin arbiter sharing one SizedFIFO enqueue port among nreq producers,
// with burst locking and a quiesce/clear/acknowledge sequencer for FIFO clears.
// Ports:
//   CLK, RST         clock, synchronous active-high reset
//   REQ, D_IN_VEC    per-requester request and data (slice i at [i*p1width +: p1width])
//   GRANT            combinational one-hot grant; the granted word is enqueued this cycle
//   FIFO_ENQ/D_IN    to the FIFO; FIFO_FULL_N from the FIFO; FIFO_CLR to the FIFO
//   CLR_REQ/CLR_ACK  clear request level / one-cycle completion pulse
//   BUSY             clear sequence in progress
module sized_fifo_enq_arb
  import sized_fifo_enq_arb_pkg::*;
#(
  parameter int unsigned p1width    = 1,
  parameter int unsigned nreq       = 4,
  parameter int unsigned ptr_width  = 2,
  parameter int unsigned max_burst  = 4,
  parameter int unsigned bcnt_width = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [nreq-1:0]         REQ,
  input  logic [nreq*p1width-1:0] D_IN_VEC,
  output logic [nreq-1:0]         GRANT,
  output logic                    FIFO_ENQ,
  output logic [p1width-1:0]      FIFO_D_IN,
  input  logic                    FIFO_FULL_N,
  output logic                    FIFO_CLR,
  input  logic                    CLR_REQ,
  output logic                    CLR_ACK,
  output logic                    BUSY
);

  arb_state_e           state_q, state_d;
  logic [ptr_width-1:0] ptr_q, ptr_d;
  logic [bcnt_width-1:0] bcnt_q, bcnt_d;
  logic                 lock_q, lock_d;

  logic [nreq-1:0]      pick_grant;
  logic [ptr_width-1:0] pick_idx;
  logic [ptr_width-1:0] ptr_inc;
  logic                 grant_en;
  logic                 same_burst;

  sized_fifo_enq_arb_rr_pick #(
    .nreq      (nreq),
    .ptr_width (ptr_width)
  ) u_rr_pick (
    .req   (REQ),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // A pending clear blocks grants in the same cycle it is raised.
  assign grant_en  = (state_q == RUN) && FIFO_FULL_N && !CLR_REQ;
  assign GRANT     = grant_en ? pick_grant : '0;
  assign FIFO_ENQ  = |GRANT;
  assign FIFO_CLR  = (state_q == CLEAR);
  assign CLR_ACK   = (state_q == ACK);
  assign BUSY      = (state_q != RUN);

  assign ptr_inc    = (pick_idx == ptr_width'(nreq - 1)) ? '0 : pick_idx + ptr_width'(1);
  assign same_burst = lock_q && (pick_idx == ptr_q);

  // Winner's data slice, zero when nothing is granted.
  always_comb begin
    FIFO_D_IN = '0;
    for (int i = 0; i < nreq; i++) begin
      if (GRANT[i]) FIFO_D_IN = D_IN_VEC[i*p1width +: p1width];
    end
  end

  // Next state: clear sequencer plus pointer/burst bookkeeping.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    bcnt_d  = '0;
    lock_d  = 1'b0;

    case (state_q)
      RUN:     if (CLR_REQ) state_d = QUIESCE;
      QUIESCE: state_d = CLEAR;
      CLEAR:   state_d = ACK;
      ACK:     state_d = RUN;
      default: state_d = RUN;
    endcase

    if (FIFO_ENQ) begin
      if (same_burst && (bcnt_q != bcnt_width'(max_burst - 1))) begin
        bcnt_d = bcnt_q + bcnt_width'(1);
        lock_d = 1'b1;
      end else if ((max_burst > 1) && !same_burst) begin
        ptr_d  = pick_idx;
        bcnt_d = bcnt_width'(1);
        lock_d = 1'b1;
      end else begin
        // Burst exhausted, or bursts disabled: move past the winner.
        ptr_d = ptr_inc;
      end
    end

    if (state_q == CLEAR) ptr_d = '0;
  end

  // State registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      ptr_q   <= '0;
      bcnt_q  <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
      lock_q  <= lock_d;
    end
  end

  // Simulation checks.
  a_grant_onehot: assert property (@(posedge CLK) disable iff (RST) $onehot0(GRANT))
    else $error("%s %m -- GRANT not one-hot-or-zero: %b", ERR_PREFIX, GRANT);

  a_no_overflow: assert property (@(posedge CLK) disable iff (RST) !(FIFO_ENQ && !FIFO_FULL_N))
    else $error("%s %m -- FIFO_ENQ while FIFO_FULL_N is low", ERR_PREFIX);

  if (nreq > (1 << ptr_width)) begin : g_bad_ptr_width
    $error("Error: sized_fifo_enq_arb: %m -- nreq exceeds 2**ptr_width");
  end

endmodule

// File: tb/tb_sized_fifo_enq_arb.sv
// Bench for sized_fifo_enq_arb: two instances (max_burst 1 and 4) share stimulus and
// are checked every cycle against a behavioural model and a FIFO scoreboard.
module tb_sized_fifo_enq_arb;

  localparam int P1W   = 8;
  localparam int NREQ  = 4;
  localparam int DEPTH = 6;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*P1W-1:0] din_vec;
  logic              clr_req;
  logic              full_n [2];
  logic [NREQ-1:0]   grant  [2];
  logic              enq    [2];
  logic [P1W-1:0]    d_out  [2];
  logic              fclr   [2];
  logic              ack    [2];
  logic              busy   [2];

  sized_fifo_enq_arb #(.p1width(P1W), .nreq(NREQ), .ptr_width(2), .max_burst(1), .bcnt_width(1)) u_dut_b1 (
    .CLK(clk), .RST(rst), .REQ(req), .D_IN_VEC(din_vec), .GRANT(grant[0]), .FIFO_ENQ(enq[0]),
    .FIFO_D_IN(d_out[0]), .FIFO_FULL_N(full_n[0]), .FIFO_CLR(fclr[0]), .CLR_REQ(clr_req),
    .CLR_ACK(ack[0]), .BUSY(busy[0]));

  sized_fifo_enq_arb #(.p1width(P1W), .nreq(NREQ), .ptr_width(2), .max_burst(4), .bcnt_width(2)) u_dut_b4 (
    .CLK(clk), .RST(rst), .REQ(req), .D_IN_VEC(din_vec), .GRANT(grant[1]), .FIFO_ENQ(enq[1]),
    .FIFO_D_IN(d_out[1]), .FIFO_FULL_N(full_n[1]), .FIFO_CLR(fclr[1]), .CLR_REQ(clr_req),
    .CLR_ACK(ack[1]), .BUSY(busy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: phase 0=RUN 1=QUIESCE 2=CLEAR 3=ACK
  int m_phase [2];
  int m_ptr   [2];
  int m_bcnt  [2];
  bit m_lock  [2];

  // Observed outputs at the last sampling point
  int sg [2];
  int sd [2];
  int sc [2];
  int sa [2];
  int sb [2];

  // FIFO scoreboard: circular buffers of actual and expected words
  bit       fifo_on;
  logic [P1W-1:0] a_mem [2][16];
  logic [P1W-1:0] e_mem [2][16];
  int a_rd [2];
  int a_cnt [2];
  int e_rd [2];
  int e_cnt [2];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int max_burst_of(input int m);
    return (m == 0) ? 1 : 4;
  endfunction

  // One clock cycle: sample at the falling edge, compare, advance model, cross posedge.
  task automatic step();
    int w [2];
    int g;
    int prev;
    int exp_data;
    #4;
    for (int m = 0; m < 2; m++) begin
      w[m] = -1;
      if (m_phase[m] == 0 && full_n[m] && !clr_req) begin
        for (int k = NREQ - 1; k >= 0; k--) begin
          if (req[(m_ptr[m] + k) % NREQ]) w[m] = (m_ptr[m] + k) % NREQ;
        end
      end
      exp_data = (w[m] >= 0) ? int'((din_vec >> (w[m] * P1W)) & 32'hFF) : 0;
      sg[m] = int'(grant[m]);
      sd[m] = int'(d_out[m]);
      sc[m] = int'(fclr[m]);
      sa[m] = int'(ack[m]);
      sb[m] = int'(busy[m]);
      check($sformatf("grant%0d", m), sg[m], (w[m] >= 0) ? (1 << w[m]) : 0);
      check($sformatf("enq%0d", m), int'(enq[m]), (w[m] >= 0) ? 1 : 0);
      check($sformatf("data%0d", m), sd[m], exp_data);
      check($sformatf("clr%0d", m), sc[m], (m_phase[m] == 2) ? 1 : 0);
      check($sformatf("ack%0d", m), sa[m], (m_phase[m] == 3) ? 1 : 0);
      check($sformatf("busy%0d", m), sb[m], (m_phase[m] != 0) ? 1 : 0);

      if (fifo_on) begin
        if (fclr[m]) begin
          a_cnt[m] = 0;
        end else if (enq[m]) begin
          check($sformatf("overflow%0d", m), (a_cnt[m] < DEPTH) ? 1 : 0, 1);
          if (a_cnt[m] < 16) begin
            a_mem[m][(a_rd[m] + a_cnt[m]) % 16] = d_out[m];
            a_cnt[m]++;
          end
        end
        if (m_phase[m] == 2) e_cnt[m] = 0;
        else if (w[m] >= 0 && e_cnt[m] < 16) begin
          e_mem[m][(e_rd[m] + e_cnt[m]) % 16] = P1W'(exp_data);
          e_cnt[m]++;
        end
        if (($urandom % 2) == 0 && a_cnt[m] > 0 && e_cnt[m] > 0) begin
          check($sformatf("fifo_word%0d", m), int'(a_mem[m][a_rd[m]]), int'(e_mem[m][e_rd[m]]));
          a_rd[m] = (a_rd[m] + 1) % 16;
          e_rd[m] = (e_rd[m] + 1) % 16;
          a_cnt[m]--;
          e_cnt[m]--;
        end
        check($sformatf("fifo_level%0d", m), a_cnt[m], e_cnt[m]);
      end

      if (rst) begin
        m_phase[m] = 0; m_ptr[m] = 0; m_bcnt[m] = 0; m_lock[m] = 1'b0;
      end else begin
        prev = m_phase[m];
        if (prev == 0) m_phase[m] = clr_req ? 1 : 0;
        else m_phase[m] = (prev + 1) % 4;
        if (w[m] >= 0) begin
          // g = number of grants this burst has received including this one
          g = (m_lock[m] && w[m] == m_ptr[m]) ? m_bcnt[m] + 1 : 1;
          if (g >= max_burst_of(m)) begin
            m_ptr[m] = (w[m] + 1) % NREQ; m_bcnt[m] = 0; m_lock[m] = 1'b0;
          end else begin
            m_ptr[m] = w[m]; m_bcnt[m] = g; m_lock[m] = 1'b1;
          end
        end else begin
          m_bcnt[m] = 0; m_lock[m] = 1'b0;
        end
        if (prev == 2) begin
          m_ptr[m] = 0; m_bcnt[m] = 0; m_lock[m] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    if (fifo_on) begin
      for (int m = 0; m < 2; m++) full_n[m] = (a_cnt[m] < DEPTH) && (($urandom % 4) != 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    clr_req = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; din_vec = '0; clr_req = 1'b0; fifo_on = 1'b0;
    full_n[0] = 1'b1; full_n[1] = 1'b1;
    for (int m = 0; m < 2; m++) begin
      m_phase[m] = 0; m_ptr[m] = 0; m_bcnt[m] = 0; m_lock[m] = 1'b0;
      a_rd[m] = 0; a_cnt[m] = 0; e_rd[m] = 0; e_cnt[m] = 0;
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    do_reset();
    check("rst_grant", sg[0], 0);
    check("rst_busy", sb[1], 0);

    // Plain round robin with bursts disabled
    din_vec = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t1_grant", sg[0], 1 << (k % 4));
      check("t1_data", sd[0], 'hA0 + (k % 4));
    end

    // Bursts of four alternate between two requesters
    do_reset();
    req = 4'b0011;
    for (int k = 0; k < 16; k++) begin
      step();
      check("t2_grant", sg[1], ((k / 4) % 2 == 1) ? 2 : 1);
    end

    // FIFO full stalls grants
    req = 4'b0100;
    full_n[0] = 1'b0; full_n[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t3_grant", sg[1], 0);
    end
    full_n[0] = 1'b1; full_n[1] = 1'b1;
    step();
    check("t3_resume0", sg[0], 4);
    check("t3_resume1", sg[1], 4);

    // Clear sequence
    req = 4'b1111;
    step();
    step();
    clr_req = 1'b1;
    step();
    check("t4_blocked", sg[0], 0);
    step();
    check("t4_quiesce", sc[0], 0);
    step();
    check("t4_clr", sc[0], 1);
    step();
    check("t4_ack", sa[1], 1);
    clr_req = 1'b0;
    step();
    check("t4_first0", sg[0], 1);
    check("t4_first1", sg[1], 1);

    // Reset in the middle of a clear
    clr_req = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    check("t5_in_clear", sc[0], 1);
    rst = 1'b0;
    clr_req = 1'b0;
    step();
    check("t5_clr_low", sc[0], 0);
    check("t5_busy_low", sb[0], 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t5_no_ack", sa[0] | sa[1], 0);
    end

    // Random traffic with a FIFO attached
    fifo_on = 1'b1;
    for (int m = 0; m < 2; m++) begin
      a_cnt[m] = 0; e_cnt[m] = 0; a_rd[m] = 0; e_rd[m] = 0;
    end
    for (int n = 0; n < 3000; n++) begin
      req = NREQ'($urandom);
      din_vec = $urandom;
      if (clr_req && sa[0] == 1) clr_req = 1'b0;
      else if (!clr_req && ($urandom % 40) == 0) clr_req = 1'b1;
      rst = (($urandom % 300) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
